// File: rtl/arbitrated_memory.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : arbitrated_memory
// Description : Single-port word memory with byte-lane writes, shared by
//               NUM_PORTS requesters through a round-robin arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module arbitrated_memory #(
    parameter int NUM_PORTS   = 2,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 17,
    parameter int WRAP        = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [4*NUM_PORTS-1:0]         we,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0] addr,
    input  logic [32*NUM_PORTS-1:0]        wdata,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [NUM_PORTS-1:0]           rvalid,
    output logic [31:0]                    rdata,
    output logic                           err
);

    localparam int C_PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int C_IDX_W = $clog2(DEPTH_WORDS);
    // Extended address always has at least one bit above the index field
    localparam int C_AXW   = (ADDR_WIDTH > C_IDX_W) ? ADDR_WIDTH : C_IDX_W + 1;
    localparam logic [C_PTR_W-1:0] C_PTR_RST = C_PTR_W'(NUM_PORTS - 1);

    logic [C_PTR_W-1:0] r_ptr;
    logic [NUM_PORTS-1:0] r_rvalid;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic [C_PTR_W-1:0] w_win;
    logic [C_PTR_W-1:0] w_cand;
    logic               w_any;
    logic               w_go;
    logic [NUM_PORTS-1:0] w_onehot;
    logic [3:0]         w_sel_we;
    logic [31:0]        w_sel_wdata;
    logic [C_AXW-1:0]   w_addr_ext;
    logic [C_IDX_W-1:0] w_idx;
    logic               w_oob;

    function automatic logic [C_PTR_W-1:0] f_cand(input logic [C_PTR_W-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return C_PTR_W'(s);
    endfunction

    // Search starts just after the last winner, so the last winner has lowest priority
    always_comb begin
        w_win  = r_ptr;
        w_any  = 1'b0;
        w_cand = r_ptr;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_cand = f_cand(r_ptr, i);
            if (!w_any && req[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    assign w_go = w_any & ~reset;

    always_comb begin
        w_onehot = '0;
        if (w_go) w_onehot[w_win] = 1'b1;
    end

    assign grant       = w_onehot;
    assign w_sel_we    = we[4*w_win +: 4];
    assign w_sel_wdata = wdata[32*w_win +: 32];
    assign w_addr_ext  = C_AXW'(addr[ADDR_WIDTH*w_win +: ADDR_WIDTH]);
    assign w_idx       = w_addr_ext[C_IDX_W-1:0];
    assign w_oob       = (WRAP == 0) && (|w_addr_ext[C_AXW-1:C_IDX_W]);

    // Memory array carries no reset so it maps onto block RAM
    always_ff @(posedge clock) begin
        if (w_go && !w_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (w_sel_we[b]) r_mem[w_idx][8*b +: 8] <= w_sel_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr    <= C_PTR_RST;
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else if (w_go) begin
            r_ptr    <= w_win;
            r_rvalid <= w_onehot;
            r_rdata  <= w_oob ? 32'h0 : r_mem[w_idx];
            r_err    <= w_oob;
        end else begin
            r_rvalid <= '0;
            r_err    <= 1'b0;
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_arbitrated_memory.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_arbitrated_memory
// Description : Directed, table-driven bench for arbitrated_memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_arbitrated_memory;

    logic        clock;
    logic        reset;

    logic [2:0]  req;
    logic [11:0] we;
    logic [50:0] addr;
    logic [95:0] wdata;
    logic [2:0]  grant;
    logic [2:0]  rvalid;
    logic [31:0] rdata;
    logic        err;

    logic [1:0]  req2;
    logic [7:0]  we2;
    logic [33:0] addr2;
    logic [63:0] wdata2;
    logic [1:0]  grant2;
    logic [1:0]  rvalid2;
    logic [31:0] rdata2;
    logic        err2;

    int checks = 0;
    int errors = 0;

    arbitrated_memory #(
        .NUM_PORTS(3), .DEPTH_WORDS(1024), .ADDR_WIDTH(17), .WRAP(1)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .grant(grant), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    arbitrated_memory #(
        .NUM_PORTS(2), .DEPTH_WORDS(1024), .ADDR_WIDTH(17), .WRAP(0)
    ) dut_nw (
        .clock(clock), .reset(reset), .req(req2), .we(we2), .addr(addr2),
        .wdata(wdata2), .grant(grant2), .rvalid(rvalid2), .rdata(rdata2), .err(err2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  req;
        logic [3:0]  we;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [2:0]  exp_grant;
        logic        chk_data;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [15];
    logic [2:0] rr_exp [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Requesting ports get the vector's fields; idle ports get junk that must be ignored
    task automatic drive(input logic [2:0] r, input logic [3:0] w, input logic [16:0] a,
                         input logic [31:0] d);
        req = r;
        for (int p = 0; p < 3; p++) begin
            we[4*p +: 4]     = r[p] ? w : 4'hF;
            addr[17*p +: 17] = r[p] ? a : 17'h1ABCD;
            wdata[32*p +: 32] = r[p] ? d : 32'hDEADBEEF;
        end
    endtask

    task automatic step2(input logic [1:0] r, input logic [3:0] w, input logic [16:0] a,
                         input logic [31:0] d, input logic [1:0] exp_g, input logic exp_err,
                         input logic chk_d, input logic [31:0] exp_d);
        req2 = r;
        for (int p = 0; p < 2; p++) begin
            we2[4*p +: 4]      = r[p] ? w : 4'hF;
            addr2[17*p +: 17]  = r[p] ? a : 17'h00005;
            wdata2[32*p +: 32] = r[p] ? d : 32'hDEADBEEF;
        end
        #1;
        chk("nw_grant", {30'h0, grant2}, {30'h0, exp_g});
        @(posedge clock);
        @(negedge clock);
        chk("nw_rvalid", {30'h0, rvalid2}, {30'h0, exp_g});
        chk("nw_err", {31'h0, err2}, {31'h0, exp_err});
        if (chk_d) chk("nw_rdata", rdata2, exp_d);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 4'h0, 17'h00000, 32'h00000000, 3'b000, 1'b1, 32'h00000000};
        vecs[1]  = '{3'b001, 4'hF, 17'h00005, 32'h12345678, 3'b001, 1'b0, 32'h00000000};
        vecs[2]  = '{3'b001, 4'h0, 17'h00005, 32'h00000000, 3'b001, 1'b1, 32'h12345678};
        vecs[3]  = '{3'b010, 4'hF, 17'h00007, 32'hAABBCCDD, 3'b010, 1'b0, 32'h00000000};
        vecs[4]  = '{3'b010, 4'h5, 17'h00007, 32'h11223344, 3'b010, 1'b1, 32'hAABBCCDD};
        vecs[5]  = '{3'b100, 4'h0, 17'h00007, 32'h00000000, 3'b100, 1'b1, 32'hAA22CC44};
        vecs[6]  = '{3'b000, 4'h0, 17'h00000, 32'h00000000, 3'b000, 1'b1, 32'hAA22CC44};
        vecs[7]  = '{3'b001, 4'hF, 17'h00003, 32'h00000042, 3'b001, 1'b0, 32'h00000000};
        vecs[8]  = '{3'b001, 4'hF, 17'h00003, 32'hFFFFFFFF, 3'b001, 1'b1, 32'h00000042};
        vecs[9]  = '{3'b001, 4'h0, 17'h00003, 32'h00000000, 3'b001, 1'b1, 32'hFFFFFFFF};
        vecs[10] = '{3'b001, 4'hF, 17'h00405, 32'hCAFEF00D, 3'b001, 1'b1, 32'h12345678};
        vecs[11] = '{3'b001, 4'h0, 17'h00005, 32'h00000000, 3'b001, 1'b1, 32'hCAFEF00D};
        vecs[12] = '{3'b110, 4'h0, 17'h00003, 32'h00000000, 3'b010, 1'b1, 32'hFFFFFFFF};
        vecs[13] = '{3'b101, 4'h0, 17'h00007, 32'h00000000, 3'b100, 1'b1, 32'hAA22CC44};
        vecs[14] = '{3'b011, 4'h0, 17'h00005, 32'h00000000, 3'b001, 1'b1, 32'hCAFEF00D};
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

        // Reset state, with a request held high to confirm grant stays low
        reset = 1'b1;
        drive(3'b001, 4'hF, 17'h00009, 32'h0BADF00D);
        req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_grant", {29'h0, grant}, 32'h0);
        chk("rst_rvalid", {29'h0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("grant[%0d]", i), {29'h0, grant}, {29'h0, vecs[i].exp_grant});
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("rvalid[%0d]", i), {29'h0, rvalid}, {29'h0, vecs[i].exp_grant});
            chk($sformatf("err[%0d]", i), {31'h0, err}, 32'h0);
            if (vecs[i].chk_data) chk($sformatf("rdata[%0d]", i), rdata, vecs[i].exp_rdata);
        end

        // Three-way contention straight out of reset
        reset = 1'b1;
        drive(3'b000, 4'h0, 17'h0, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        drive(3'b111, 4'h0, 17'h00005, 32'h0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_grant[%0d]", k), {29'h0, grant}, {29'h0, rr_exp[k]});
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("rr_rvalid[%0d]", k), {29'h0, rvalid}, {29'h0, rr_exp[k]});
        end

        // Reset in the middle of a port 1 write burst
        drive(3'b010, 4'hF, 17'h00009, 32'h00000055);
        @(posedge clock);
        @(negedge clock);
        drive(3'b010, 4'hF, 17'h00009, 32'h000000A1);
        @(posedge clock);
        @(negedge clock);
        chk("burst_rvalid", {29'h0, rvalid}, 32'h2);
        chk("burst_rdata", rdata, 32'h00000055);
        drive(3'b010, 4'hF, 17'h00009, 32'h0000DEAD);
        reset = 1'b1;
        #1;
        chk("midrst_rvalid", {29'h0, rvalid}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_err", {31'h0, err}, 32'h0);
        chk("midrst_grant", {29'h0, grant}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        drive(3'b011, 4'h0, 17'h00009, 32'h0);
        #1;
        chk("postrst_grant", {29'h0, grant}, 32'h1);
        @(posedge clock);
        @(negedge clock);
        chk("postrst_rvalid", {29'h0, rvalid}, 32'h1);
        chk("postrst_rdata", rdata, 32'h000000A1);
        drive(3'b000, 4'h0, 17'h0, 32'h0);

        // Out-of-range handling without wrap
        step2(2'b01, 4'hF, 17'h00005, 32'h00005555, 2'b01, 1'b0, 1'b0, 32'h0);
        step2(2'b01, 4'hF, 17'h00405, 32'h00000BAD, 2'b01, 1'b1, 1'b1, 32'h0);
        step2(2'b00, 4'h0, 17'h00000, 32'h00000000, 2'b00, 1'b0, 1'b1, 32'h0);
        step2(2'b10, 4'h0, 17'h00005, 32'h00000000, 2'b10, 1'b0, 1'b1, 32'h00005555);
        step2(2'b01, 4'h0, 17'h003FF, 32'h00000000, 2'b01, 1'b0, 1'b0, 32'h0);
        step2(2'b01, 4'h0, 17'h00400, 32'h00000000, 2'b01, 1'b1, 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
